xpar_bridge: RTL and testbench
==============================

Name: xpar_bridge

Overview:
- Parametrised external parallel-bus bridge that replaces the single-cycle, combinational par_* interface at the SoC top level.
- Sits between the address decoder's external select and off-chip or slow peripherals.
- Adds programmable setup, strobe and hold wait states, acknowledge-extended strobes and a timeout with error reporting.
- All external outputs are registered, so they are glitch-free.

Parameters:
- DATA_W, 32, data width of both buses.
- ADDR_W, 10, external address width.
- SETUP_CYC, 1, address/data setup cycles before strobe (0 allowed).
- STROBE_MIN, 2, minimum strobe cycles (>=1).
- HOLD_CYC, 1, address/data hold cycles after strobe (0 allowed).
- TIMEOUT, 64, maximum strobe cycles before abort (>=STROBE_MIN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_sel  in  1  transaction request; sampled only when busy=0.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  transaction address.
- req_wdata  in  DATA_W  write data.
- req_rdata  out  DATA_W  last read data.
- req_ready  out  1  one-cycle completion pulse.
- req_err  out  1  timeout flag, valid with req_ready.
- busy  out  1  transaction in progress.
- par_addr  out  ADDR_W  external address.
- par_out  out  DATA_W  external write data.
- par_in  in  DATA_W  external read data.
- par_re  out  1  read strobe.
- par_we  out  1  write strobe.
- par_ack  in  1  external acknowledge, synchronous to clk.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including par_re, par_we, par_addr, par_out, req_rdata, req_ready, req_err and busy. Strobes drop immediately.
- States: IDLE, SETUP, STROBE, HOLD.
- One counter, width clog2(TIMEOUT+1), cleared on every state entry.
- IDLE: busy=0.
  - If req_sel=1 at a clock edge: capture req_we, drive par_addr<=req_addr and (if write) par_out<=req_wdata, set busy=1.
  - Next state is SETUP, or STROBE if SETUP_CYC=0.
- SETUP: strobes low; stay SETUP_CYC cycles, then go to STROBE.
- STROBE: par_re=~we or par_we=we, high for every cycle in STROBE. Count strobe cycles n, starting at 1.
  - Exit with success at the end of cycle n if n>=STROBE_MIN and par_ack=1 in that cycle. For a read, latch req_rdata<=par_in in that cycle.
  - Otherwise, if n==TIMEOUT, exit with err: req_rdata<=0 for reads; writes leave it unchanged.
  - The next state is HOLD, or IDLE if HOLD_CYC=0.
  - par_ack before STROBE_MIN is ignored; par_ack outside STROBE is ignored.
- HOLD: strobes low; par_addr and par_out held; stay HOLD_CYC cycles, then go to IDLE.
- Completion: in the first IDLE cycle, req_ready=1 for exactly one cycle. req_err=1 in the same cycle if the transaction timed out, else 0. busy=0 in that cycle.
  - A req_sel in the ready cycle is accepted, so back-to-back transactions have no dead cycle.
- Latency: with the request sampled in cycle 0 and ack available, req_ready is high in cycle 1+SETUP_CYC+max(STROBE_MIN,n_ack)+HOLD_CYC.
- req_sel while busy=1 is ignored and not queued; the master must wait for req_ready.
- par_addr and par_out keep their last value in IDLE; par_out is unchanged by reads.
- Reset mid-transaction aborts with no req_ready pulse. The first request after reset release behaves normally.

Decomposition:
- Package xpar_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - a counter-width function clog2;
  - parameter legality checks (STROBE_MIN>=1, TIMEOUT>=STROBE_MIN).
- One natural sub-module, xpar_cnt: a loadable/clearable down/up wait counter with terminal-count output, shared by the setup, strobe and hold phases.

Test Plan:
- Write, defaults, par_ack tied high: req_sel/req_we in cycle 0, addr 0x055, data 0xDEADBEEF -> par_addr=0x055 and par_out=0xDEADBEEF from cycle 1; par_we high cycles 2-3; req_ready=1 in cycle 5, req_err=0.
- Read, ack delayed: par_ack rises in cycle 6 with par_in=0x12345678 -> par_re high cycles 2-6; req_ready in cycle 8; req_rdata=0x12345678.
- Timeout, TIMEOUT=8, par_ack held 0, read -> par_re high 8 cycles (2-9); req_ready and req_err high in cycle 11; req_rdata=0.
- Request while busy: second req_sel in cycle 2 with addr 0x0AA -> par_addr stays 0x055; exactly one req_ready pulse.
- Reset mid-strobe: rst low in cycle 3 of a write -> par_we, busy and par_addr go 0 without a clock edge; no req_ready. After release, a new read completes with normal latency.
- SETUP_CYC=0, HOLD_CYC=0, STROBE_MIN=1, ack high -> strobe in cycle 1, req_ready in cycle 2. A new req_sel in cycle 2 gives its strobe in cycle 3 and ready in cycle 4.

Source files
------------

// File: rtl/xpar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : xpar_pkg
// Brief    : Shared types and elaboration helpers for the external bus bridge.
// Revision : 1.0
// ---------------------------------------------------------------------------
package xpar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic bit params_ok(input int setup_cyc, input int strobe_min,
                                   input int hold_cyc, input int timeout);
    return (strobe_min >= 1) && (timeout >= strobe_min) &&
           (setup_cyc <= timeout) && (hold_cyc <= timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xpar_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : xpar_cnt
// Brief    : Loadable/clearable up/down wait counter with terminal-count flag.
// Revision : 1.0
// ---------------------------------------------------------------------------
module xpar_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_down,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_down ? (r_cnt - W'(1)) : (r_cnt + W'(1));
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule
`default_nettype wire

// File: rtl/xpar_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : xpar_bridge
// Brief    : External parallel-bus bridge with setup/strobe/hold wait states,
//            ack-extended strobes, timeout abort and fully registered outputs.
// Revision : 1.0
// ---------------------------------------------------------------------------
module xpar_bridge
  import xpar_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_MIN = 2,
  parameter int HOLD_CYC   = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_sel,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] req_rdata,
  output logic              req_ready,
  output logic              req_err,
  output logic              busy,
  output logic [ADDR_W-1:0] par_addr,
  output logic [DATA_W-1:0] par_out,
  input  logic [DATA_W-1:0] par_in,
  output logic              par_re,
  output logic              par_we,
  input  logic              par_ack
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  generate
    if (!params_ok(SETUP_CYC, STROBE_MIN, HOLD_CYC, TIMEOUT)) begin : g_bad_params
      $error("xpar_bridge: illegal SETUP_CYC/STROBE_MIN/HOLD_CYC/TIMEOUT combination");
    end
  endgenerate

  state_t              r_state, w_next;
  logic                r_we, r_err_pend;
  logic [DATA_W-1:0]   r_rdata, r_out;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ready, r_err, r_busy, r_re, r_wes;
  logic [CNT_W-1:0]    w_cnt, w_term, w_n;
  logic                w_tc, w_cnt_clr, w_accept, w_ack_ok, w_timeout;
  logic                w_finish, w_we_nxt, w_err_final;

  xpar_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (w_cnt_clr),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (1'b1),
    .i_down     (1'b0),
    .i_term     (w_term),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // w_n is the 1-based strobe cycle number while in STROBE.
  assign w_n = w_cnt + CNT_W'(1);

  always_comb begin
    w_next    = r_state;
    w_term    = '0;
    w_accept  = 1'b0;
    w_ack_ok  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_sel) begin
          w_accept = 1'b1;
          w_next   = (SETUP_CYC == 0) ? ST_STROBE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_term = CNT_W'(SETUP_CYC - 1);
        if (w_tc) w_next = ST_STROBE;
      end
      ST_STROBE: begin
        w_term    = CNT_W'(TIMEOUT - 1);
        w_ack_ok  = par_ack && (w_n >= CNT_W'(STROBE_MIN));
        w_timeout = w_tc && !w_ack_ok;
        if (w_ack_ok || w_tc) w_next = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        w_term = CNT_W'(HOLD_CYC - 1);
        if (w_tc) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_cnt_clr   = (w_next != r_state) || (r_state == ST_IDLE);
  assign w_finish    = (r_state != ST_IDLE) && (w_next == ST_IDLE);
  assign w_we_nxt    = w_accept ? req_we : r_we;
  // With HOLD_CYC=0 the timeout verdict comes straight from STROBE.
  assign w_err_final = (r_state == ST_STROBE) ? w_timeout : r_err_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_err_pend <= 1'b0;
      r_addr     <= '0;
      r_out      <= '0;
      r_rdata    <= '0;
      r_re       <= 1'b0;
      r_wes      <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we   <= req_we;
        r_addr <= req_addr;
        if (req_we) r_out <= req_wdata;
      end
      r_re    <= (w_next == ST_STROBE) && !w_we_nxt;
      r_wes   <= (w_next == ST_STROBE) && w_we_nxt;
      r_busy  <= (w_next != ST_IDLE);
      r_ready <= w_finish;
      r_err   <= w_finish && w_err_final;
      if ((r_state == ST_STROBE) && (w_next != ST_STROBE)) r_err_pend <= w_timeout;
      if ((r_state == ST_STROBE) && !r_we) begin
        if (w_ack_ok)       r_rdata <= par_in;
        else if (w_timeout) r_rdata <= '0;
      end
    end
  end

  assign req_rdata = r_rdata;
  assign req_ready = r_ready;
  assign req_err   = r_err;
  assign busy      = r_busy;
  assign par_addr  = r_addr;
  assign par_out   = r_out;
  assign par_re    = r_re;
  assign par_we    = r_wes;

endmodule
`default_nettype wire

// File: tb/tb_xpar_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_xpar_bridge
// Brief    : Directed self-checking bench for xpar_bridge (two configurations).
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_xpar_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_sel, a_we, a_ready, a_err, a_busy, a_re, a_pwe, a_ack;
  logic [9:0]  a_addr, a_paddr;
  logic [31:0] a_wdata, a_rdata, a_pout, a_pin;
  logic        b_sel, b_we, b_ready, b_err, b_busy, b_re, b_pwe, b_ack;
  logic [9:0]  b_addr, b_paddr;
  logic [31:0] b_wdata, b_rdata, b_pout, b_pin;

  int total = 0;
  int bad   = 0;

  xpar_bridge #(.TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_sel(a_sel), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_rdata(a_rdata), .req_ready(a_ready), .req_err(a_err), .busy(a_busy),
    .par_addr(a_paddr), .par_out(a_pout), .par_in(a_pin),
    .par_re(a_re), .par_we(a_pwe), .par_ack(a_ack)
  );

  xpar_bridge #(.SETUP_CYC(0), .STROBE_MIN(1), .HOLD_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_sel(b_sel), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_rdata(b_rdata), .req_ready(b_ready), .req_err(b_err), .busy(b_busy),
    .par_addr(b_paddr), .par_out(b_pout), .par_in(b_pin),
    .par_re(b_re), .par_we(b_pwe), .par_ack(b_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_sel = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_pin = '0; a_ack = 0;
    b_sel = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_pin = '0; b_ack = 0;
    #12;
    check("rst re",    a_re,    0);
    check("rst we",    a_pwe,   0);
    check("rst addr",  a_paddr, 0);
    check("rst out",   a_pout,  0);
    check("rst rdata", a_rdata, 0);
    check("rst ready", a_ready, 0);
    check("rst err",   a_err,   0);
    check("rst busy",  a_busy,  0);
    @(negedge clk) rst = 1'b1;
    tick(); tick();

    // Write with ack tied high.
    a_ack = 1; a_sel = 1; a_we = 1; a_addr = 10'h055; a_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      a_sel = 0;
      check($sformatf("t1 we c%0d", k),    a_pwe,   (k == 2 || k == 3));
      check($sformatf("t1 re c%0d", k),    a_re,    0);
      check($sformatf("t1 rdy c%0d", k),   a_ready, (k == 5));
      check($sformatf("t1 busy c%0d", k),  a_busy,  (k < 5));
      check($sformatf("t1 addr c%0d", k),  a_paddr, 10'h055);
      check($sformatf("t1 out c%0d", k),   a_pout,  32'hDEADBEEF);
    end
    check("t1 err", a_err, 0);

    // Read with acknowledge arriving in cycle 6.
    a_ack = 0; a_sel = 1; a_we = 0; a_addr = 10'h100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      a_sel = 0;
      if (k == 6) begin a_ack = 1; a_pin = 32'h12345678; end
      else        begin a_ack = 0; a_pin = 32'hFFFFFFFF; end
      check($sformatf("t2 re c%0d", k),   a_re,    (k >= 2 && k <= 6));
      check($sformatf("t2 rdy c%0d", k),  a_ready, (k == 8));
      check($sformatf("t2 addr c%0d", k), a_paddr, 10'h100);
      check($sformatf("t2 out c%0d", k),  a_pout,  32'hDEADBEEF);
    end
    check("t2 rdata", a_rdata, 32'h12345678);
    check("t2 err",   a_err,   0);

    // Read timeout (TIMEOUT=8) with ack held low.
    a_ack = 0; a_sel = 1; a_we = 0; a_addr = 10'h3FF;
    for (int k = 1; k <= 11; k++) begin
      tick();
      a_sel = 0;
      check($sformatf("t3 re c%0d", k),   a_re,    (k >= 2 && k <= 9));
      check($sformatf("t3 rdy c%0d", k),  a_ready, (k == 11));
      check($sformatf("t3 busy c%0d", k), a_busy,  (k < 11));
    end
    check("t3 err",   a_err,   1);
    check("t3 rdata", a_rdata, 0);

    // Request while busy must be dropped.
    a_ack = 1; a_sel = 1; a_we = 1; a_addr = 10'h055; a_wdata = 32'h0BADF00D;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) begin a_sel = 1; a_addr = 10'h0AA; a_wdata = 32'h11111111; end
      else        a_sel = 0;
      check($sformatf("t4 addr c%0d", k), a_paddr, 10'h055);
      check($sformatf("t4 out c%0d", k),  a_pout,  32'h0BADF00D);
      check($sformatf("t4 rdy c%0d", k),  a_ready, (k == 5));
    end

    // Asynchronous reset in the middle of a write strobe.
    a_ack = 0; a_sel = 1; a_we = 1; a_addr = 10'h2AA; a_wdata = 32'h5555AAAA;
    tick(); a_sel = 0;
    tick(); tick();
    check("t5 we pre", a_pwe, 1);
    #2 rst = 1'b0;
    #1;
    check("t5 we async",   a_pwe,   0);
    check("t5 busy async", a_busy,  0);
    check("t5 addr async", a_paddr, 0);
    check("t5 out async",  a_pout,  0);
    tick(); tick();
    check("t5 rdy in rst", a_ready, 0);
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t5 no rdy c%0d", k), a_ready, 0);
    end
    a_ack = 1; a_pin = 32'hCAFEF00D; a_sel = 1; a_we = 0; a_addr = 10'h123;
    for (int k = 1; k <= 5; k++) begin
      tick();
      a_sel = 0;
      check($sformatf("t5 re c%0d", k),  a_re,    (k == 2 || k == 3));
      check($sformatf("t5 rdy c%0d", k), a_ready, (k == 5));
    end
    check("t5 rdata", a_rdata, 32'hCAFEF00D);

    // Zero setup/hold, single-cycle strobe, back-to-back requests.
    b_ack = 1; b_sel = 1; b_we = 1; b_addr = 10'h011; b_wdata = 32'h00000001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin b_sel = 1; b_we = 0; b_addr = 10'h022; b_pin = 32'hA5A5A5A5; end
      else        b_sel = 0;
      check($sformatf("t6 we c%0d", k),   b_pwe,   (k == 1));
      check($sformatf("t6 re c%0d", k),   b_re,    (k == 3));
      check($sformatf("t6 rdy c%0d", k),  b_ready, (k == 2 || k == 4));
      check($sformatf("t6 busy c%0d", k), b_busy,  (k == 1 || k == 3));
      check($sformatf("t6 err c%0d", k),  b_err,   0);
      if (k == 1) check("t6 addr1", b_paddr, 10'h011);
      if (k == 3) check("t6 addr2", b_paddr, 10'h022);
    end
    check("t6 rdata", b_rdata, 32'hA5A5A5A5);
    check("t6 out",   b_pout,  32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
